// File: rtl/mustang_lamp_pkg.sv
// mustang_lamp_pkg
//   Shared definitions for the tail-lamp sequencer:
//   - the mode encodings (the values driven on Mode)
//   - the FSM state encodings
//   - the lamp pattern constants
//   - helpers that map a state to its mode and a mode to its first phase
//   R patterns are written for a [0:2] vector, so the leftmost bit is R[0],
//   the inner lamp.
package mustang_lamp_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HAZ   = 2'b11
    } mode_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_L0, ST_L1, ST_L2, ST_LOFF,
        ST_R0, ST_R1, ST_R2, ST_ROFF, ST_HON, ST_HOFF
    } state_t;

    localparam logic [2:0] LAMP_OFF    = 3'b000;
    localparam logic [2:0] LAMP_ALL    = 3'b111;
    localparam logic [2:0] LAMP_L_SEQ1 = 3'b001;
    localparam logic [2:0] LAMP_R_SEQ1 = 3'b100;
    localparam logic [2:0] LAMP_L_SEQ2 = 3'b011;
    localparam logic [2:0] LAMP_R_SEQ2 = 3'b110;

    function automatic mode_t state_mode(input state_t s);
        case (s)
            ST_L0, ST_L1, ST_L2, ST_LOFF: state_mode = MODE_LEFT;
            ST_R0, ST_R1, ST_R2, ST_ROFF: state_mode = MODE_RIGHT;
            ST_HON, ST_HOFF:              state_mode = MODE_HAZ;
            default:                      state_mode = MODE_IDLE;
        endcase
    endfunction

    function automatic state_t mode_entry(input mode_t m);
        case (m)
            MODE_LEFT:  mode_entry = ST_L0;
            MODE_RIGHT: mode_entry = ST_R0;
            MODE_HAZ:   mode_entry = ST_HON;
            default:    mode_entry = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lamp_step_timer.sv
// lamp_step_timer
//   Animation prescaler. Counts 0..STEP_DIV-1 and wraps to 0; a synchronous
//   clear, which takes priority over the wrap, restarts the count.
//   Step is registered and is high in the cycle where the count is STEP_DIV-1.
//   Ports: Clk, Reset (async, active low), clear (sync restart), step (pulse).
module lamp_step_timer #(
    parameter int STEP_DIV = 25_000_000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    output logic step
);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_nxt;

    always_comb begin
        cnt_nxt = cnt_q + 1'b1;
        if (clear || cnt_q == LAST)
            cnt_nxt = '0;
    end

    // Step is taken from the next count so that it lines up with the count
    // register: high exactly while cnt_q == LAST.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
            step  <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            step  <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/mustang_lamp_sequencer.sv
// mustang_lamp_sequencer
//   Rear tail-lamp controller, with three lamps on each side.
//   - It synchronises the Left/Right/Hazard requests.
//   - It arbitrates the requests into one mode.
//   - It steps the lamp animation on the prescaled Step tick.
//   Ports:
//     Clk, Reset          clock; async active-low reset
//     Left, Right, Hazard async level requests
//     Brake               async level brake input (LAMP_BRAKE_EN builds only)
//     L[2:0], R[0:2]      lamp drives; index 0 is the inner lamp
//     Mode[1:0]           active mode (00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZ)
//     Step                one-cycle pulse per animation step
//   Build option: define LAMP_BRAKE_EN to add the Brake input. While Brake
//   is active, the lamp side that is not animating lights fully.
//   All outputs are registered. L, R and Mode are loaded from the decode of
//   the next state, so they change on the same edge as the FSM. An input
//   edge therefore reaches the lamps after SYNC_STAGES+1 clock edges.
module mustang_lamp_sequencer
    import mustang_lamp_pkg::*;
#(
    parameter int STEP_DIV    = 25_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Left,
    input  logic       Right,
    input  logic       Hazard,
`ifdef LAMP_BRAKE_EN
    input  logic       Brake,
`endif
    output logic [2:0] L,
    output logic [0:2] R,
    output logic [1:0] Mode,
    output logic       Step
);
    localparam int NREQ = 4;  // {brake, hazard, right, left}

    logic [NREQ-1:0]                  req_raw, req_s;
    logic [SYNC_STAGES-1:0][NREQ-1:0] sync_pipe;
    state_t     state_q, state_nxt;
    mode_t      req_mode;
    logic       timer_clr;
    logic [2:0] l_nxt;
    logic [0:2] r_nxt;

`ifdef LAMP_BRAKE_EN
    assign req_raw = {Brake, Hazard, Right, Left};
`else
    assign req_raw = {1'b0, Hazard, Right, Left};
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], req_raw};
    end
    assign req_s = sync_pipe[SYNC_STAGES-1];

    always_comb begin
        if (req_s[2] || (req_s[0] && req_s[1])) req_mode = MODE_HAZ;
        else if (req_s[0])                      req_mode = MODE_LEFT;
        else if (req_s[1])                      req_mode = MODE_RIGHT;
        else                                    req_mode = MODE_IDLE;
    end

    lamp_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (timer_clr),
        .step  (Step)
    );

    // A mode change wins over a Step that arrives in the same cycle.
    always_comb begin
        state_nxt = state_q;
        timer_clr = 1'b0;
        if (req_mode != state_mode(state_q)) begin
            state_nxt = mode_entry(req_mode);
            timer_clr = 1'b1;
        end else if (Step) begin
            case (state_q)
                ST_L0:   state_nxt = ST_L1;
                ST_L1:   state_nxt = ST_L2;
                ST_L2:   state_nxt = ST_LOFF;
                ST_LOFF: state_nxt = ST_L0;
                ST_R0:   state_nxt = ST_R1;
                ST_R1:   state_nxt = ST_R2;
                ST_R2:   state_nxt = ST_ROFF;
                ST_ROFF: state_nxt = ST_R0;
                ST_HON:  state_nxt = ST_HOFF;
                ST_HOFF: state_nxt = ST_HON;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Lamp decode of the next state. Brake (req_s[3]) only fills the idle side.
    always_comb begin
        l_nxt = LAMP_OFF;
        r_nxt = LAMP_OFF;
        case (state_nxt)
            ST_L0:   l_nxt = LAMP_L_SEQ1;
            ST_L1:   l_nxt = LAMP_L_SEQ2;
            ST_L2:   l_nxt = LAMP_ALL;
            ST_R0:   r_nxt = LAMP_R_SEQ1;
            ST_R1:   r_nxt = LAMP_R_SEQ2;
            ST_R2:   r_nxt = LAMP_ALL;
            ST_HON: begin
                l_nxt = LAMP_ALL;
                r_nxt = LAMP_ALL;
            end
            default: ;
        endcase
        if (req_s[3]) begin
            case (state_mode(state_nxt))
                MODE_IDLE: begin
                    l_nxt = LAMP_ALL;
                    r_nxt = LAMP_ALL;
                end
                MODE_LEFT:  r_nxt = LAMP_ALL;
                MODE_RIGHT: l_nxt = LAMP_ALL;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            L       <= LAMP_OFF;
            R       <= LAMP_OFF;
            Mode    <= MODE_IDLE;
        end else begin
            state_q <= state_nxt;
            L       <= l_nxt;
            R       <= r_nxt;
            Mode    <= state_mode(state_nxt);
        end
    end

endmodule

// File: tb/tb_mustang_lamp_sequencer.sv
// tb_mustang_lamp_sequencer
//   Directed bench for mustang_lamp_sequencer with STEP_DIV=4 and SYNC_STAGES=2.
//   Inputs are driven on the falling edge and outputs are sampled on the
//   falling edge. Expected values are written as {L, R, Mode}, where R is
//   written R[0] first.
module tb_mustang_lamp_sequencer;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       Left, Right, Hazard;
`ifdef LAMP_BRAKE_EN
    logic       Brake;
`endif
    logic [2:0] L;
    logic [0:2] R;
    logic [1:0] Mode;
    logic       Step;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] obs, exp;

    always #5 Clk = ~Clk;

    mustang_lamp_sequencer #(.STEP_DIV(4), .SYNC_STAGES(2)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Left   (Left),
        .Right  (Right),
        .Hazard (Hazard),
`ifdef LAMP_BRAKE_EN
        .Brake  (Brake),
`endif
        .L      (L),
        .R      (R),
        .Mode   (Mode),
        .Step   (Step)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic test_reset;
        Reset = 1'b0; Left = 1'b0; Right = 1'b0; Hazard = 1'b0;
`ifdef LAMP_BRAKE_EN
        Brake = 1'b0;
`endif
        cyc(3);
        n_cmp++;
        if ({L, R, Mode, Step} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_values: got %b want %b", {L, R, Mode, Step}, 9'b0);
        end
        Reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            obs = {L, R, Mode};
            n_cmp++;
            if (obs !== 8'b0) begin
                n_bad++;
                $display("FAIL idle_hold[%0d]: got %b want %b", i, obs, 8'b0);
            end
            n_cmp++;
            if (Step !== ((i % 4) == 2)) begin
                n_bad++;
                $display("FAIL idle_step[%0d]: got %b want %b", i, Step, (i % 4) == 2);
            end
        end
    endtask

    task automatic test_left;
        logic [2:0] seq [4];
        seq[0] = 3'b011; seq[1] = 3'b111; seq[2] = 3'b000; seq[3] = 3'b001;
        Left = 1'b1;
        cyc(2);
        obs = {L, R, Mode};
        n_cmp++;
        if (obs !== 8'b0) begin
            n_bad++;
            $display("FAIL left_latency_early: got %b want %b", obs, 8'b0);
        end
        cyc(1);
        obs = {L, R, Mode}; exp = {3'b001, 3'b000, 2'b01};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL left_entry: got %b want %b", obs, exp);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(4);
            obs = {L, R, Mode}; exp = {seq[k], 3'b000, 2'b01};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL left_seq[%0d]: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_right;
        cyc(4);  // L1, with the timer just wrapped
        obs = {L, R, Mode}; exp = {3'b011, 3'b000, 2'b01};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL right_pre_L1: got %b want %b", obs, exp);
        end
        Left = 1'b0; Right = 1'b1;
        cyc(3);
        obs = {L, R, Mode}; exp = {3'b000, 3'b100, 2'b10};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL right_entry: got %b want %b", obs, exp);
        end
        // Without the clear, the timer would fire Step on this very cycle.
        n_cmp++;
        if (Step !== 1'b0) begin
            n_bad++;
            $display("FAIL right_clear_step: got %b want 0", Step);
        end
        cyc(2);
        n_cmp++;
        if (Step !== 1'b0) begin
            n_bad++;
            $display("FAIL right_step_early: got %b want 0", Step);
        end
        cyc(1);
        n_cmp++;
        if ({Step, R} !== 4'b1100) begin
            n_bad++;
            $display("FAIL right_step_due: got %b want %b", {Step, R}, 4'b1100);
        end
        cyc(1);
        obs = {L, R, Mode}; exp = {3'b000, 3'b110, 2'b10};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL right_R1: got %b want %b", obs, exp);
        end
    endtask

    task automatic test_hazard;
        logic [7:0] pat [3];
        pat[0] = {3'b111, 3'b111, 2'b11};
        pat[1] = {3'b000, 3'b000, 2'b11};
        pat[2] = {3'b111, 3'b111, 2'b11};
        Left = 1'b1;  // Left with Right active is treated as hazard
        cyc(3);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) cyc(4);
            obs = {L, R, Mode};
            n_cmp++;
            if (obs !== pat[k]) begin
                n_bad++;
                $display("FAIL haz_lr[%0d]: got %b want %b", k, obs, pat[k]);
            end
        end
        Left = 1'b0; Right = 1'b0;
        cyc(3);
        obs = {L, R, Mode};
        n_cmp++;
        if (obs !== 8'b0) begin
            n_bad++;
            $display("FAIL haz_to_idle: got %b want %b", obs, 8'b0);
        end
        Hazard = 1'b1;
        cyc(3);
        obs = {L, R, Mode};
        n_cmp++;
        if (obs !== pat[0]) begin
            n_bad++;
            $display("FAIL haz_only_on: got %b want %b", obs, pat[0]);
        end
        cyc(4);
        obs = {L, R, Mode};
        n_cmp++;
        if (obs !== pat[1]) begin
            n_bad++;
            $display("FAIL haz_only_off: got %b want %b", obs, pat[1]);
        end
    endtask

    task automatic test_reset_mid;
        cyc(5);  // one cycle into HON
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({L, R, Mode, Step} !== 9'b0) begin
            n_bad++;
            $display("FAIL midreset_async: got %b want %b", {L, R, Mode, Step}, 9'b0);
        end
        cyc(2);
        Reset = 1'b1;
        cyc(2);
        obs = {L, R, Mode};
        n_cmp++;
        if (obs !== 8'b0) begin
            n_bad++;
            $display("FAIL midreset_refill: got %b want %b", obs, 8'b0);
        end
        cyc(1);
        obs = {L, R, Mode}; exp = {3'b111, 3'b111, 2'b11};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL midreset_hon: got %b want %b", obs, exp);
        end
    endtask

`ifdef LAMP_BRAKE_EN
    task automatic test_brake;
        logic [7:0] exps [6];
        int         waits [6];
        Hazard = 1'b0;
        cyc(4);
        exps[0] = {3'b111, 3'b111, 2'b00}; waits[0] = 3;  // brake only
        exps[1] = {3'b001, 3'b111, 2'b01}; waits[1] = 3;  // + Left
        exps[2] = {3'b011, 3'b111, 2'b01}; waits[2] = 4;
        exps[3] = {3'b111, 3'b111, 2'b11}; waits[3] = 3;  // + Hazard
        exps[4] = {3'b000, 3'b000, 2'b11}; waits[4] = 4;
        exps[5] = {3'b111, 3'b111, 2'b11}; waits[5] = 4;  // brake released
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: Brake = 1'b1;
                1: Left = 1'b1;
                3: Hazard = 1'b1;
                5: Brake = 1'b0;
                default: ;
            endcase
            cyc(waits[k]);
            obs = {L, R, Mode};
            n_cmp++;
            if (obs !== exps[k]) begin
                n_bad++;
                $display("FAIL brake[%0d]: got %b want %b", k, obs, exps[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_left;
        test_right;
        test_hazard;
        test_reset_mid;
`ifdef LAMP_BRAKE_EN
        test_brake;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
